// File: rtl/uart_baud_if.sv
// uart_baud_if: configuration, line and tick bundle between register block/receiver and baud controller
interface uart_baud_if #(parameter int DIV_W = 16);
    logic             en;
    logic [DIV_W-1:0] div;
    logic             sample_type;
    logic             rx_in;
    logic             rx_done;
    logic             btick_16;
    logic             btick;
    logic             mid_tick;
    logic             locked;
    modport master (output en, div, sample_type, rx_in, rx_done,
                    input  btick_16, btick, mid_tick, locked);
    modport slave  (input  en, div, sample_type, rx_in, rx_done,
                    output btick_16, btick, mid_tick, locked);
endinterface

// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: baud prescaler, 16x/13x oversample counter and start-bit phase realignment
module uart_baud_ctrl #(parameter int DIV_W = 16) (
    input  logic        clk,
    input  logic        rst_n,
    uart_baud_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           st, st_n;
    logic [DIV_W-1:0] pcnt, pcnt_n, div_q, deff;
    logic [3:0]       ocnt, ocnt_n, n_m1, m;
    logic [2:0]       rx_sync;
    logic             type_q, cfg_vld, chg, fall, wrap;
    logic             tick16_n, btick_n, mid_n;

    assign deff = (bus.div < DIV_W'(2)) ? DIV_W'(1) : bus.div;
    assign n_m1 = bus.sample_type ? 4'd12 : 4'd15;
    assign m    = bus.sample_type ? 4'd6 : 4'd7;
    // cfg_vld keeps the first cycle after reset from seeing a spurious change
    assign chg  = cfg_vld && (bus.div != div_q || bus.sample_type != type_q);
    assign fall = rx_sync[2] && !rx_sync[1];
    assign wrap = pcnt == deff - DIV_W'(1);
    assign bus.locked = st == RUN;

    always_comb begin
        pcnt_n = wrap ? '0 : pcnt + DIV_W'(1);
        ocnt_n = !wrap ? ocnt : (ocnt == n_m1) ? 4'd0 : ocnt + 4'd1;
        st_n   = (st == RUN && bus.rx_done) ? IDLE : st;
        if (!bus.en || chg || (st == IDLE && fall)) begin
            pcnt_n = '0;
            ocnt_n = '0;
            st_n   = (bus.en && !chg) ? RUN : IDLE;
        end
        // ticks are decided one cycle ahead so the outputs come straight from flops
        tick16_n = bus.en && !chg && pcnt_n == deff - DIV_W'(1);
        btick_n  = tick16_n && ocnt_n == n_m1;
        mid_n    = tick16_n && ocnt_n == m;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync      <= 3'b111;
            div_q        <= '0;
            type_q       <= 1'b0;
            cfg_vld      <= 1'b0;
            pcnt         <= '0;
            ocnt         <= '0;
            st           <= IDLE;
            bus.btick_16 <= 1'b0;
            bus.btick    <= 1'b0;
            bus.mid_tick <= 1'b0;
        end else begin
            rx_sync      <= {rx_sync[1:0], bus.rx_in};
            div_q        <= bus.div;
            type_q       <= bus.sample_type;
            cfg_vld      <= 1'b1;
            pcnt         <= pcnt_n;
            ocnt         <= ocnt_n;
            st           <= st_n;
            bus.btick_16 <= tick16_n;
            bus.btick    <= btick_n;
            bus.mid_tick <= mid_n;
        end
    end
endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb_uart_baud_ctrl: directed checks of tick spacing, realignment, frame end, config change and enable
module tb_uart_baud_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   f16, fb, fm, fl, n16, nb, nm, nl;

    uart_baud_if #(.DIV_W(16)) bus ();
    uart_baud_ctrl #(.DIV_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // run len edges, recording the first edge index (1-based, 0 = never) and count of each output
    task automatic watch(input int len);
        f16 = 0; fb = 0; fm = 0; fl = 0; n16 = 0; nb = 0; nm = 0; nl = 0;
        for (int i = 1; i <= len; i++) begin
            step();
            if (bus.btick_16) begin n16++; if (f16 == 0) f16 = i; end
            if (bus.btick)    begin nb++;  if (fb == 0)  fb = i;  end
            if (bus.mid_tick) begin nm++;  if (fm == 0)  fm = i;  end
            if (bus.locked)   begin nl++;  if (fl == 0)  fl = i;  end
        end
    endtask

    initial begin
        bus.en = 1'b1; bus.div = 16'd4; bus.sample_type = 1'b0;
        bus.rx_in = 1'b1; bus.rx_done = 1'b0;
        repeat (3) step();
        check("rst_outs", {bus.locked, bus.mid_tick, bus.btick, bus.btick_16}, 0);
        rst_n = 1'b1;
        // 16x, div=4: counters start at 0 on release
        watch(70);
        check("x16_first_b16", f16, 3);
        check("x16_n_b16", n16, 17);
        check("x16_first_mid", fm, 31);
        check("x16_first_btick", fb, 63);
        check("x16_n_btick", nb, 1);
        check("x16_n_mid", nm, 1);
        check("x16_unlocked", nl, 0);
        watch(64);
        check("x16_per_b16", n16, 16);
        check("x16_per_btick", fb, 57);
        check("x16_per_mid", fm, 25);
        // reset asserted while a tick is on the outputs
        for (int i = 0; i < 8 && !bus.btick_16; i++) step();
        check("pre_rst_tick", int'(bus.btick_16), 1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {bus.locked, bus.mid_tick, bus.btick, bus.btick_16}, 0);
        step();
        rst_n = 1'b1;
        watch(10);
        check("rst_rel_b16", f16, 3);
        // 13x, div=3: change edge clears counters
        bus.div = 16'd3; bus.sample_type = 1'b1;
        watch(80);
        check("x13_first_b16", f16, 3);
        check("x13_n_b16", n16, 26);
        check("x13_first_mid", fm, 21);
        check("x13_first_btick", fb, 39);
        check("x13_n_btick", nb, 2);
        check("x13_n_mid", nm, 2);
        // realign at div=2, 16x
        bus.div = 16'd2; bus.sample_type = 1'b0;
        watch(5);
        bus.rx_in = 1'b0;
        watch(40);
        check("ra_lock_at", fl, 3);
        check("ra_first_mid", fm, 18);
        check("ra_first_btick", fb, 34);
        check("ra_n_lock", nl, 38);
        bus.rx_in = 1'b1;
        watch(4);
        bus.rx_in = 1'b0;
        watch(10);
        check("ra2_ignored_mid", fm, 6);
        check("ra2_still_locked", nl, 10);
        // frame end: unlock without disturbing the phase
        bus.rx_done = 1'b1;
        step();
        bus.rx_done = 1'b0;
        check("done_unlock", int'(bus.locked), 0);
        watch(12);
        check("done_phase_b16", f16, 1);
        check("done_phase_btick", fb, 11);
        check("done_idle", nl, 0);
        bus.rx_in = 1'b1;
        repeat (3) step();
        bus.rx_in = 1'b0;
        watch(20);
        check("ra3_lock_at", fl, 3);
        check("ra3_first_mid", fm, 18);
        // oversampling switch while locked
        bus.sample_type = 1'b1;
        watch(30);
        check("sw_unlocked", nl, 0);
        check("sw_first_b16", f16, 2);
        check("sw_first_mid", fm, 14);
        check("sw_first_btick", fb, 26);
        // div=0 and div=1 behave the same
        bus.div = 16'd0; bus.sample_type = 1'b0;
        watch(40);
        check("d0_first_b16", f16, 2);
        check("d0_n_b16", n16, 39);
        check("d0_first_mid", fm, 8);
        check("d0_first_btick", fb, 16);
        check("d0_n_btick", nb, 2);
        check("d0_n_mid", nm, 3);
        bus.div = 16'd1;
        watch(40);
        check("d1_first_b16", f16, 2);
        check("d1_n_b16", n16, 39);
        check("d1_first_mid", fm, 8);
        check("d1_first_btick", fb, 16);
        check("d1_n_btick", nb, 2);
        // enable low for 10 clocks, then restart at div=3
        bus.en = 1'b0; bus.div = 16'd3;
        watch(10);
        check("en_off_b16", n16, 0);
        check("en_off_mid", nm + nb, 0);
        bus.en = 1'b1;
        watch(10);
        check("en_on_first_b16", f16, 2);
        check("en_on_n_b16", n16, 3);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

Baud-rate and sampling-phase controller for the UART receive path. It divides the system clock into the oversampling tick `btick_16` and the bit tick `btick` that sequence the receive shift register, and supports 16x and 13x oversampling. On each start-bit falling edge it realigns the bit phase to the incoming frame. It sits between the register block (divisor, oversampling select, enable) and the receive shift register.

## Interface
Parameters:
- `DIV_W`, 16, width of the baud divisor.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `en`  input  1  generator enable; low holds all counters at 0 and suppresses ticks.
- `div`  input  DIV_W  system clocks per oversampling tick; 0 and 1 both mean 1.
- `sample_type`  input  1  oversampling select: 0 = 16x, 1 = 13x.
- `rx_in`  input  1  raw serial line, asynchronous to `clk`.
- `rx_done`  input  1  single-cycle pulse from the receiver when a frame (stop bit) completes.
- `btick_16`  output  1  one-`clk`-wide oversampling tick.
- `btick`  output  1  one-`clk`-wide bit tick, coincident with the last `btick_16` of a bit period.
- `mid_tick`  output  1  one-`clk`-wide bit-centre sample tick.
- `locked`  output  1  high while in RUN, i.e. bit phase aligned to the current frame.

## Operation
- Prescaler `pcnt` (DIV_W bits):
  - Counts 0..Deff-1, where Deff = max(`div`, 1).
  - `btick_16` = 1 in the cycle where `pcnt` == Deff-1 and `en` = 1; `pcnt` wraps to 0 in that same cycle.
- Oversample counter `ocnt` (4 bits):
  - N = 16 when `sample_type` = 0, N = 13 when `sample_type` = 1.
  - Advances only on `btick_16` and wraps N-1 -> 0.
  - `btick` = `btick_16` & (`ocnt` == N-1).
  - `mid_tick` = `btick_16` & (`ocnt` == M), where M = 7 for 16x and M = 6 for 13x.
- `rx_in` passes through a 2-flop synchronizer; falling-edge detect runs on the synchronized value.
- FSM states:
  - IDLE:
    - Counters free-run; `locked` = 0.
    - A synchronized falling edge with `en` = 1 clears `pcnt` and `ocnt` to 0 in the next cycle and moves to RUN.
  - RUN:
    - `locked` = 1; counters free-run; falling edges are ignored (no mid-frame realignment).
    - `rx_done` = 1 returns the FSM to IDLE. Counters are not cleared, so phase continues.
- Configuration change:
  - Triggered when `div` or `sample_type` differs from the value registered in the previous cycle while `en` = 1.
  - Next cycle: `pcnt` = 0, `ocnt` = 0, FSM -> IDLE. No tick is emitted in the change cycle.
- `en` low: `pcnt` = 0, `ocnt` = 0, FSM = IDLE, all tick outputs 0. On `en` rising, counting starts from 0.
- Simultaneous events, by priority:
  1. `en` low
  2. Configuration change
  3. Falling edge in IDLE
  4. `rx_done`
  5. Normal count
- Falling edge and `rx_done` in the same cycle while in RUN: go to IDLE, no realign.

## Timing
- Reset values: `btick_16` = 0, `btick` = 0, `mid_tick` = 0, `locked` = 0, `pcnt` = 0, `ocnt` = 0, FSM = IDLE, synchronizer flops = 1 (line idle).
- All outputs are registered; no combinational path from input to output.
- `btick_16` period = Deff clocks; `btick` period = N·Deff clocks.
- Edge-to-realign latency:
  - `rx_in` falling at cycle t is seen by the edge detector at t+2.
  - Counters read 0 at t+3.
  - First `mid_tick` at t+3+(M+1)·Deff-1; first `btick` at t+3+N·Deff-1.
- Reset mid-operation: all state returns to reset values immediately; the first tick appears Deff clocks after `rst_n` release, given `en` = 1.
- `div` = 1: `btick_16` is high every cycle and `btick` every N cycles.

## Test plan
- Reset:
  - Assert `rst_n` = 0 mid-count with `en` = 1, `div` = 4 -> all outputs 0 immediately.
  - After release, first `btick_16` on the 4th clock.
- 16x rate:
  - `div` = 4, `sample_type` = 0, `rx_in` = 1 -> `btick_16` every 4 clk, `btick` every 64 clk.
  - `mid_tick` 32 clk after the counters reach 0; `locked` stays 0.
- 13x rate:
  - `div` = 3, `sample_type` = 1 -> `btick` every 39 clk, `mid_tick` at `ocnt` = 6.
  - Switching `sample_type` mid-stream clears counters and drops `locked`; no tick in the change cycle.
- Realign:
  - `div` = 2, 16x; drive `rx_in` 1->0 at an arbitrary phase -> counters read 0 three clocks later and `locked` = 1.
  - First `mid_tick` 16 clk after that, first `btick` 32 clk after that.
  - A second falling edge before `rx_done` is ignored.
- Frame end:
  - Pulse `rx_done` while in RUN -> `locked` = 0 next cycle with no counter discontinuity.
  - The next falling edge realigns again.
- Boundaries:
  - `div` = 0 behaves identically to `div` = 1 (`btick_16` high every cycle).
  - `en` = 0 for 10 clk -> no ticks; after re-enable, first `btick_16` after Deff clocks.
